// File: rtl/fakeram7_pkg.sv
// Shared definitions for the fakeram7 dual-port controller: default macro geometry and FSM encoding.
package fakeram7_pkg;

    localparam int DEF_BITS       = 32;
    localparam int DEF_WORD_DEPTH = 8192;
    localparam int DEF_ADDR_WIDTH = 13;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/fakeram7_rsp_fifo.sv
// Two-entry response buffer for one port; rsp_valid is simply "not empty".
module fakeram7_rsp_fifo
    import fakeram7_pkg::*;
#(
    parameter int BITS = DEF_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [BITS-1:0] push_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [BITS-1:0] rsp_data,
    output logic [1:0]      count
);

    logic [BITS-1:0] mem [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic            pop;

    assign rsp_valid = (count != 2'd0);
    assign rsp_data  = mem[rd_ptr];
    assign pop       = rsp_valid && rsp_ready;

    // Push and pop in the same cycle leave the occupancy unchanged, even when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            if (push && !pop)      count <= count + 2'd1;
            else if (pop && !push) count <= count - 2'd1;
        end
    end

endmodule

// File: rtl/fakeram7_dp_ctrl.sv
// Request-side controller for a 1-cycle dual-port fakeram7 macro with optional power-up clear.
// Optional perf counters (perf_ops, perf_stalls) are built when FAKERAM7_DP_CTRL_PERF_EN is defined.
module fakeram7_dp_ctrl
    import fakeram7_pkg::*;
#(
    parameter int BITS           = DEF_BITS,
    parameter int WORD_DEPTH     = DEF_WORD_DEPTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_a_valid,
    output logic                  req_a_ready,
    input  logic                  req_a_we,
    input  logic [ADDR_WIDTH-1:0] req_a_addr,
    input  logic [BITS-1:0]       req_a_wdata,
    input  logic [BITS-1:0]       req_a_wmask,
    input  logic                  req_b_valid,
    output logic                  req_b_ready,
    input  logic                  req_b_we,
    input  logic [ADDR_WIDTH-1:0] req_b_addr,
    input  logic [BITS-1:0]       req_b_wdata,
    input  logic [BITS-1:0]       req_b_wmask,
    output logic                  rsp_a_valid,
    input  logic                  rsp_a_ready,
    output logic [BITS-1:0]       rsp_a_rdata,
    output logic                  rsp_b_valid,
    input  logic                  rsp_b_ready,
    output logic [BITS-1:0]       rsp_b_rdata,
    output logic                  ram_ce,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic                  ram_we_a,
    output logic                  ram_we_b,
    output logic [BITS-1:0]       ram_wd_a,
    output logic [BITS-1:0]       ram_wd_b,
    output logic [BITS-1:0]       ram_wmask_a,
    output logic [BITS-1:0]       ram_wmask_b,
    input  logic [BITS-1:0]       ram_rd_a,
    input  logic [BITS-1:0]       ram_rd_b,
    output logic                  init_done
`ifdef FAKERAM7_DP_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_ops,
    output logic [31:0]           perf_stalls
`endif
);

    localparam logic [1:0] S_INIT  = INIT;
    localparam logic [1:0] S_CLEAR = CLEAR;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [ADDR_WIDTH-2:0] CLR_LAST = (ADDR_WIDTH-1)'(WORD_DEPTH / 2 - 1);

    logic [1:0]            state;
    logic [ADDR_WIDTH-2:0] clr_cnt;
    logic [ADDR_WIDTH-1:0] last_addr_a, last_addr_b;
    logic                  rd_pend_a, rd_pend_b;
    logic [1:0]            occ_a, occ_b;
    logic [1:0]            load_a, load_b;
    logic                  run, hazard, iss_a, iss_b;

    assign run    = (state == S_RUN);
    assign load_a = occ_a + {1'b0, rd_pend_a};
    assign load_b = occ_b + {1'b0, rd_pend_b};

    // A always wins a same-address conflict involving a write, so B sees A's write a cycle later.
    assign hazard      = req_a_valid && (req_a_addr == req_b_addr) && (req_a_we || req_b_we);
    assign req_a_ready = run && (load_a < 2'd2);
    assign req_b_ready = run && (load_b < 2'd2) && !hazard;
    assign iss_a       = req_a_valid && req_a_ready;
    assign iss_b       = req_b_valid && req_b_ready;

    always_comb begin
        ram_ce      = 1'b0;
        ram_addr_a  = last_addr_a;
        ram_addr_b  = last_addr_b;
        ram_we_a    = 1'b0;
        ram_we_b    = 1'b0;
        ram_wd_a    = '0;
        ram_wd_b    = '0;
        ram_wmask_a = '0;
        ram_wmask_b = '0;
        if (state == S_CLEAR) begin
            ram_ce      = 1'b1;
            ram_addr_a  = {clr_cnt, 1'b0};
            ram_addr_b  = {clr_cnt, 1'b1};
            ram_we_a    = 1'b1;
            ram_we_b    = 1'b1;
            ram_wmask_a = '1;
            ram_wmask_b = '1;
        end else begin
            ram_ce = iss_a || iss_b;
            if (iss_a) begin
                ram_addr_a  = req_a_addr;
                ram_we_a    = req_a_we;
                ram_wd_a    = req_a_wdata;
                ram_wmask_a = req_a_wmask;
            end
            if (iss_b) begin
                ram_addr_b  = req_b_addr;
                ram_we_b    = req_b_we;
                ram_wd_b    = req_b_wdata;
                ram_wmask_b = req_b_wmask;
            end
        end
    end

    // Idle ports replay their last address so the macro pins never float while ram_ce is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_INIT;
            clr_cnt     <= '0;
            init_done   <= 1'b0;
            last_addr_a <= '0;
            last_addr_b <= '0;
            rd_pend_a   <= 1'b0;
            rd_pend_b   <= 1'b0;
        end else begin
            last_addr_a <= ram_addr_a;
            last_addr_b <= ram_addr_b;
            rd_pend_a   <= iss_a && !req_a_we;
            rd_pend_b   <= iss_b && !req_b_we;
            case (state)
                S_INIT: begin
                    if (CLEAR_ON_RESET != 0) begin
                        state <= S_CLEAR;
                    end else begin
                        state     <= S_RUN;
                        init_done <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == CLR_LAST) begin
                        state     <= S_RUN;
                        init_done <= 1'b1;
                    end
                end
                S_RUN:   init_done <= 1'b1;
                default: state <= S_INIT;
            endcase
        end
    end

    fakeram7_rsp_fifo #(.BITS(BITS)) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend_a),
        .push_data (ram_rd_a),
        .rsp_valid (rsp_a_valid),
        .rsp_ready (rsp_a_ready),
        .rsp_data  (rsp_a_rdata),
        .count     (occ_a)
    );

    fakeram7_rsp_fifo #(.BITS(BITS)) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend_b),
        .push_data (ram_rd_b),
        .rsp_valid (rsp_b_valid),
        .rsp_ready (rsp_b_ready),
        .rsp_data  (rsp_b_rdata),
        .count     (occ_b)
    );

`ifdef FAKERAM7_DP_CTRL_PERF_EN
    logic [32:0] ops_sum;
    assign ops_sum = {1'b0, perf_ops} + {31'd0, iss_a} + {31'd0, iss_b};

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops    <= '0;
            perf_stalls <= '0;
        end else begin
            perf_ops <= ops_sum[32] ? '1 : ops_sum[31:0];
            if (run && req_b_valid && hazard && (perf_stalls != '1))
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fakeram7_dp_ctrl.sv
// Directed self-checking bench for fakeram7_dp_ctrl paired with a behavioural dual-port 8192x32 macro.
module tb_fakeram7_dp_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_a_valid = 1'b0, req_a_we = 1'b0, req_b_valid = 1'b0, req_b_we = 1'b0;
    logic [12:0] req_a_addr = '0, req_b_addr = '0;
    logic [31:0] req_a_wdata = '0, req_a_wmask = '0, req_b_wdata = '0, req_b_wmask = '0;
    logic        req_a_ready, req_b_ready;
    logic        rsp_a_valid, rsp_b_valid;
    logic        rsp_a_ready = 1'b1, rsp_b_ready = 1'b1;
    logic [31:0] rsp_a_rdata, rsp_b_rdata;
    logic        ram_ce, ram_we_a, ram_we_b;
    logic [12:0] ram_addr_a, ram_addr_b;
    logic [31:0] ram_wd_a, ram_wd_b, ram_wmask_a, ram_wmask_b;
    logic [31:0] ram_rd_a = '0, ram_rd_b = '0;
    logic        init_done;
`ifdef FAKERAM7_DP_CTRL_PERF_EN
    logic [31:0] perf_ops, perf_stalls;
`endif

    int check_count = 0;
    int pass_count  = 0;

    always #5 clk = ~clk;

    fakeram7_dp_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_a_valid (req_a_valid),
        .req_a_ready (req_a_ready),
        .req_a_we    (req_a_we),
        .req_a_addr  (req_a_addr),
        .req_a_wdata (req_a_wdata),
        .req_a_wmask (req_a_wmask),
        .req_b_valid (req_b_valid),
        .req_b_ready (req_b_ready),
        .req_b_we    (req_b_we),
        .req_b_addr  (req_b_addr),
        .req_b_wdata (req_b_wdata),
        .req_b_wmask (req_b_wmask),
        .rsp_a_valid (rsp_a_valid),
        .rsp_a_ready (rsp_a_ready),
        .rsp_a_rdata (rsp_a_rdata),
        .rsp_b_valid (rsp_b_valid),
        .rsp_b_ready (rsp_b_ready),
        .rsp_b_rdata (rsp_b_rdata),
        .ram_ce      (ram_ce),
        .ram_addr_a  (ram_addr_a),
        .ram_addr_b  (ram_addr_b),
        .ram_we_a    (ram_we_a),
        .ram_we_b    (ram_we_b),
        .ram_wd_a    (ram_wd_a),
        .ram_wd_b    (ram_wd_b),
        .ram_wmask_a (ram_wmask_a),
        .ram_wmask_b (ram_wmask_b),
        .ram_rd_a    (ram_rd_a),
        .ram_rd_b    (ram_rd_b),
        .init_done   (init_done)
`ifdef FAKERAM7_DP_CTRL_PERF_EN
        ,
        .perf_ops    (perf_ops),
        .perf_stalls (perf_stalls)
`endif
    );

    // Behavioural fakeram7: synchronous masked write, registered read; starts full of ones.
    logic [31:0] mem [0:8191];
    initial for (int i = 0; i < 8192; i++) mem[i] = 32'hFFFF_FFFF;

    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we_a) mem[ram_addr_a] <= (mem[ram_addr_a] & ~ram_wmask_a) | (ram_wd_a & ram_wmask_a);
            else          ram_rd_a <= mem[ram_addr_a];
            if (ram_we_b) mem[ram_addr_b] <= (mem[ram_addr_b] & ~ram_wmask_b) | (ram_wd_b & ram_wmask_b);
            else          ram_rd_b <= mem[ram_addr_b];
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input bit port, input bit valid, input bit we, input logic [12:0] addr,
                                 input logic [31:0] wd, input logic [31:0] wm);
        if (!port) begin
            req_a_valid = valid; req_a_we = we; req_a_addr = addr; req_a_wdata = wd; req_a_wmask = wm;
        end else begin
            req_b_valid = valid; req_b_we = we; req_b_addr = addr; req_b_wdata = wd; req_b_wmask = wm;
        end
    endtask

    // Entered and left at 1 time unit after a rising edge; leaves right after the accepting edge.
    task automatic issueOne(input bit port, input bit we, input logic [12:0] addr,
                            input logic [31:0] wd, input logic [31:0] wm);
        int waited = 0;
        logic rdy;
        applyStimulus(port, 1'b1, we, addr, wd, wm);
        #1;
        rdy = port ? req_b_ready : req_a_ready;
        while (!rdy && waited < 20) begin
            @(posedge clk); #2;
            waited++;
            rdy = port ? req_b_ready : req_a_ready;
        end
        if (!rdy) checkOutput("issue_timeout", {31'd0, rdy}, 32'd1);
        @(posedge clk); #1;
        applyStimulus(port, 1'b0, 1'b0, addr, 32'd0, 32'd0);
    endtask

    task automatic expectRsp(input bit port, input string tag, input logic [31:0] expected);
        logic vld;
        for (int i = 0; i < 20; i++) begin
            vld = port ? rsp_b_valid : rsp_a_valid;
            if (vld) begin
                checkOutput(tag, port ? rsp_b_rdata : rsp_a_rdata, expected);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        vld = port ? rsp_b_valid : rsp_a_valid;
        checkOutput({tag, "_timeout"}, {31'd0, vld}, 32'd1);
    endtask

    task automatic waitInit(input string tag);
        int cycles = 0;
        while (!init_done && cycles < 5000) begin
            @(posedge clk); #1;
            cycles++;
            if (cycles == 2) checkOutput({tag, "_clr_addr_b"}, {19'd0, ram_addr_b}, 32'd3);
        end
        checkOutput(tag, cycles, 32'd4097);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ctl"},
                    {26'd0, init_done, req_a_ready, req_b_ready, rsp_a_valid, rsp_b_valid, ram_ce}, 32'd0);
        checkOutput({tag, "_addr"}, {6'd0, ram_addr_a, ram_addr_b}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst_n = 1'b1;
        waitInit("init_cycles");
        checkOutput("run_ready_a", {31'd0, req_a_ready}, 32'd1);

        issueOne(0, 0, 13'h0000, 32'd0, 32'd0);
        expectRsp(0, "clr_rd_0000", 32'd0);
        issueOne(1, 0, 13'h1FFF, 32'd0, 32'd0);
        expectRsp(1, "clr_rd_1fff", 32'd0);

        // Write then read back with exact one-edge latency from the accepting edge.
        issueOne(0, 1, 13'h0010, 32'hDEADBEEF, 32'hFFFFFFFF);
        issueOne(0, 0, 13'h0010, 32'd0, 32'd0);
        checkOutput("lat_a_early", {31'd0, rsp_a_valid}, 32'd0);
        @(posedge clk); #1;
        checkOutput("lat_a_valid", {31'd0, rsp_a_valid}, 32'd1);
        checkOutput("lat_a_data", rsp_a_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Same-address write on A and read on B in one cycle.
        applyStimulus(0, 1, 1, 13'h0020, 32'h12345678, 32'hFFFFFFFF);
        applyStimulus(1, 1, 0, 13'h0020, 32'd0, 32'd0);
        #1;
        checkOutput("haz_ready_a", {31'd0, req_a_ready}, 32'd1);
        checkOutput("haz_ready_b", {31'd0, req_b_ready}, 32'd0);
        @(posedge clk); #1;
        applyStimulus(0, 0, 0, 13'h0020, 32'd0, 32'd0);
        #1;
        checkOutput("haz_ready_b_next", {31'd0, req_b_ready}, 32'd1);
        @(posedge clk); #1;
        applyStimulus(1, 0, 0, 13'h0020, 32'd0, 32'd0);
        expectRsp(1, "haz_rd_b", 32'h12345678);
`ifdef FAKERAM7_DP_CTRL_PERF_EN
        checkOutput("perf_stalls", perf_stalls, 32'd1);
        checkOutput("perf_ops", perf_ops, 32'd6);
`endif

        // Partial-mask write through port B, read back on A.
        issueOne(1, 1, 13'h0030, 32'h55555555, 32'hFFFFFFFF);
        issueOne(1, 1, 13'h0030, 32'hAAAAAAAA, 32'h0000FFFF);
        issueOne(0, 0, 13'h0030, 32'd0, 32'd0);
        expectRsp(0, "mask_rd", 32'h5555AAAA);

        // Credit limit: with responses blocked the third read must wait.
        rsp_a_ready = 1'b0;
        applyStimulus(0, 1, 0, 13'h0010, 32'd0, 32'd0);
        #1; checkOutput("bp_rdy1", {31'd0, req_a_ready}, 32'd1);
        @(posedge clk); #1;
        applyStimulus(0, 1, 0, 13'h0020, 32'd0, 32'd0);
        #1; checkOutput("bp_rdy2", {31'd0, req_a_ready}, 32'd1);
        @(posedge clk); #1;
        applyStimulus(0, 1, 0, 13'h0030, 32'd0, 32'd0);
        #1; checkOutput("bp_rdy3_held", {31'd0, req_a_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_still_held", {31'd0, req_a_ready}, 32'd0);
        checkOutput("bp_head", rsp_a_rdata, 32'hDEADBEEF);
        rsp_a_ready = 1'b1;
        @(posedge clk); #1;
        rsp_a_ready = 1'b0;
        #1;
        checkOutput("bp_rdy_after_pop", {31'd0, req_a_ready}, 32'd1);
        @(posedge clk); #1;
        applyStimulus(0, 0, 0, 13'h0030, 32'd0, 32'd0);
        rsp_a_ready = 1'b1;
        expectRsp(0, "bp_second", 32'h12345678);
        expectRsp(0, "bp_third", 32'h5555AAAA);

        // Reset during RUN drops a buffered response.
        rsp_a_ready = 1'b0;
        issueOne(0, 0, 13'h0010, 32'd0, 32'd0);
        @(posedge clk); #1;
        checkOutput("pre_rst_valid", {31'd0, rsp_a_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("rst_run");
        @(posedge clk); #1;
        rsp_a_ready = 1'b1;
        rst_n = 1'b1;

        // Reset during CLEAR at count 1000, then the full clear repeats.
        repeat (1001) @(posedge clk);
        #1;
        checkOutput("clr_mid_addr", {19'd0, ram_addr_a}, 32'd2000);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("rst_clear");
        @(posedge clk); #1;
        rst_n = 1'b1;
        waitInit("reinit_cycles");
        issueOne(0, 0, 13'h0010, 32'd0, 32'd0);
        expectRsp(0, "reclr_rd_0010", 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
